// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED pattern generator:
// mode codes, channel state encoding and the per-channel config bundle.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Config fields travel at full width; each channel keeps only CNT_W/BURST_W bits.
  localparam int MAX_CNT_W   = 32;
  localparam int MAX_BURST_W = 32;

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_ON    = 2'b01,
    S_BLINK = 2'b10,
    S_BURST = 2'b11
  } state_t;

  typedef struct packed {
    logic [1:0]             mode;
    logic [MAX_CNT_W-1:0]   period;
    logic [MAX_CNT_W-1:0]   on_time;
    logic [MAX_BURST_W-1:0] count;
  } chan_cfg_t;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Write-only configuration port: a one-cycle strobe plus channel select and settings.
// No backpressure; every strobe is consumed in the cycle it is presented.
interface led_blink_ctrl_if #(
  parameter int CH_NUM  = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_on_time;
  logic [BURST_W-1:0] cfg_count;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on_time, cfg_count);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on_time, cfg_count);

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: OFF/ON/BLINK/BURST FSM with phase and burst-remaining counters.
// Outputs registered, one cycle after a write or tick; a write always wins over a tick.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  logic      wr,
  input  chan_cfg_t cfg,
  output logic      led,
  output logic      busy,
  output logic      done
);

  state_t             state;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   on_time;
  logic [CNT_W-1:0]   phase;
  logic [BURST_W-1:0] remaining;

  logic [CNT_W-1:0]   w_period;
  logic [CNT_W-1:0]   w_on_time;
  logic [BURST_W-1:0] w_count;
  logic [CNT_W-1:0]   phase_nxt;
  logic               wrap;
  logic               cfg_unused;

  assign w_period   = cfg.period[CNT_W-1:0];
  assign w_on_time  = cfg.on_time[CNT_W-1:0];
  assign w_count    = cfg.count[BURST_W-1:0];
  assign cfg_unused = ^cfg;

  assign wrap      = (phase == period - CNT_W'(1));
  assign phase_nxt = wrap ? '0 : phase + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_OFF;
      period    <= '0;
      on_time   <= '0;
      phase     <= '0;
      remaining <= '0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr) begin
        period    <= w_period;
        on_time   <= w_on_time;
        phase     <= '0;
        remaining <= w_count;
        case (cfg.mode)
          MODE_ON: begin
            state <= S_ON;
            led   <= 1'b1;
            busy  <= 1'b0;
          end
          MODE_BLINK: begin
            state <= S_BLINK;
            led   <= (w_period != '0) && (w_on_time != '0);
            busy  <= 1'b1;
          end
          MODE_BURST: begin
            // A zero-length burst completes immediately without lighting the LED.
            if (w_period == '0 || w_count == '0) begin
              state <= S_OFF;
              led   <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_BURST;
              led   <= (w_on_time != '0);
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= S_OFF;
            led   <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end else if (tick && period != '0) begin
        case (state)
          S_BLINK: begin
            phase <= phase_nxt;
            led   <= (phase_nxt < on_time);
          end
          S_BURST: begin
            if (wrap && remaining == BURST_W'(1)) begin
              state     <= S_OFF;
              phase     <= '0;
              remaining <= '0;
              led       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              phase <= phase_nxt;
              led   <= (phase_nxt < on_time);
              if (wrap) remaining <= remaining - BURST_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// CH_NUM LED pattern channels sharing one prescaled tick; config writes land next cycle.
// No backpressure; enable=0 freezes the prescaler and hence every channel's pattern.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 16,
  parameter int BURST_W  = 8,
  parameter int PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  led_blink_ctrl_if.slave   cfg,
  output logic [CH_NUM-1:0] led_o,
  output logic [CH_NUM-1:0] busy_o,
  output logic [CH_NUM-1:0] done_o
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  chan_cfg_t       cfg_bus;

  assign tick = enable && (ps_cnt == PS_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt <= '0;
    end else if (enable) begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end
  end

  always_comb begin
    cfg_bus         = '0;
    cfg_bus.mode    = cfg.cfg_mode;
    cfg_bus.period  = MAX_CNT_W'(cfg.cfg_period);
    cfg_bus.on_time = MAX_CNT_W'(cfg.cfg_on_time);
    cfg_bus.count   = MAX_BURST_W'(cfg.cfg_count);
  end

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    logic wr;
    assign wr = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    led_blink_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .wr      (wr),
      .cfg     (cfg_bus),
      .led     (led_o[i]),
      .busy    (busy_o[i]),
      .done    (done_o[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl (3 channels, tick every 4 clocks): directed scenarios plus
// random config traffic, all scored cycle by cycle against a tick-count reference model.
module tb_led_blink_ctrl;

  localparam int CH = 3;
  localparam int PS = 4;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [CH-1:0] led_o;
  logic [CH-1:0] busy_o;
  logic [CH-1:0] done_o;

  led_blink_ctrl_if #(.CH_NUM(CH), .CNT_W(16), .BURST_W(8)) cfg_if ();

  led_blink_ctrl #(
    .CH_NUM   (CH),
    .CNT_W    (16),
    .BURST_W  (8),
    .PRESCALE (PS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .cfg     (cfg_if.slave),
    .led_o   (led_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel is described by its config and the number of
  // ticks seen since it was written; outputs follow from division and modulo.
  int            en_cycles;
  int            m_mode  [CH];
  int            m_per   [CH];
  int            m_on    [CH];
  int            m_cnt   [CH];
  int            m_ticks [CH];
  logic [CH-1:0] e_led, e_busy, e_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    en_cycles = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_per[c] = 0; m_on[c] = 0; m_cnt[c] = 0; m_ticks[c] = 0;
    end
    e_led = '0; e_busy = '0; e_done = '0;
  endtask

  task automatic model_step();
    bit tk;
    tk = enable && ((en_cycles % PS) == PS - 1);
    if (enable) en_cycles++;
    e_done = '0;
    for (int c = 0; c < CH; c++) begin
      if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == c) begin
        m_mode[c]  = int'(cfg_if.cfg_mode);
        m_per[c]   = int'(cfg_if.cfg_period);
        m_on[c]    = int'(cfg_if.cfg_on_time);
        m_cnt[c]   = int'(cfg_if.cfg_count);
        m_ticks[c] = 0;
        case (m_mode[c])
          0: begin e_led[c] = 0; e_busy[c] = 0; end
          1: begin e_led[c] = 1; e_busy[c] = 0; end
          2: begin e_led[c] = (m_per[c] != 0) && (m_on[c] != 0); e_busy[c] = 1; end
          default: begin
            if (m_per[c] == 0 || m_cnt[c] == 0) begin
              e_led[c] = 0; e_busy[c] = 0; e_done[c] = 1; m_mode[c] = 0;
            end else begin
              e_led[c] = (m_on[c] != 0); e_busy[c] = 1;
            end
          end
        endcase
      end else if (tk && m_mode[c] >= 2 && m_per[c] != 0) begin
        m_ticks[c]++;
        if (m_mode[c] == 3 && (m_ticks[c] / m_per[c]) >= m_cnt[c]) begin
          e_led[c] = 0; e_busy[c] = 0; e_done[c] = 1; m_mode[c] = 0;
        end else begin
          e_led[c] = (m_ticks[c] % m_per[c]) < m_on[c];
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("led_o",  32'(led_o),  32'(e_led));
    check_eq("busy_o", 32'(busy_o), 32'(e_busy));
    check_eq("done_o", 32'(done_o), 32'(e_done));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr_cfg(input int ch, input int mode, input int per, input int on, input int cnt);
    cfg_if.cfg_we      = 1'b1;
    cfg_if.cfg_ch      = 2'(ch);
    cfg_if.cfg_mode    = 2'(mode);
    cfg_if.cfg_period  = 16'(per);
    cfg_if.cfg_on_time = 16'(on);
    cfg_if.cfg_count   = 8'(cnt);
    cycle();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_led",  32'(led_o),  32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_step();
    check_eq("rel_led", 32'(led_o), 32'(e_led));
  endtask

  int rises, dones;
  logic prev;
  logic [CH-1:0] hold_led;

  initial begin
    reset_n = 1'b1;
    enable  = 1'b1;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_period = '0; cfg_if.cfg_on_time = '0; cfg_if.cfg_count = '0;
    #2;
    do_reset(3);

    // Idle after reset
    run(100);

    // ON / OFF
    wr_cfg(2, 1, 0, 0, 0);
    check_eq("on_ch2", 32'(led_o), 32'b100);
    wr_cfg(2, 0, 0, 0, 0);
    check_eq("off_ch2", 32'(led_o), 32'b000);

    // BLINK duty, then on_time beyond period
    wr_cfg(0, 2, 4, 1, 0);
    run(48);
    wr_cfg(0, 2, 4, 5, 0);
    run(20);
    check_eq("blink_full_led", 32'(led_o[0]), 32'd1);
    check_eq("blink_full_busy", 32'(busy_o[0]), 32'd1);
    wr_cfg(0, 0, 0, 0, 0);

    // BURST of three, then a zero-count burst
    wr_cfg(1, 3, 2, 1, 3);
    rises = 1; dones = 0; prev = led_o[1];
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (led_o[1] && !prev) rises++;
      if (done_o[1]) dones++;
      prev = led_o[1];
    end
    check_eq("burst_pulses", 32'(rises), 32'd3);
    check_eq("burst_dones", 32'(dones), 32'd1);
    check_eq("burst_idle", 32'({busy_o[1], led_o[1]}), 32'd0);
    wr_cfg(1, 3, 2, 1, 0);
    check_eq("burst0_done", 32'(done_o[1]), 32'd1);
    cycle();
    check_eq("burst0_pulse", 32'(done_o[1]), 32'd0);

    // Rewrite mid-burst: only the new burst reports done
    wr_cfg(1, 3, 2, 1, 3);
    run(10);
    wr_cfg(1, 3, 2, 1, 2);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (done_o[1]) dones++;
    end
    check_eq("rewrite_dones", 32'(dones), 32'd1);

    // Freeze mid-blink, then resume
    wr_cfg(0, 2, 4, 2, 0);
    run(10);
    hold_led = led_o;
    enable = 1'b0;
    run(20);
    check_eq("freeze_led", 32'(led_o), 32'(hold_led));
    enable = 1'b1;
    run(30);

    // Out-of-range channel after quieting everything
    for (int c = 0; c < CH; c++) wr_cfg(c, 0, 0, 0, 0);
    wr_cfg(3, 1, 0, 0, 0);
    check_eq("bad_ch_led", 32'(led_o), 32'd0);
    check_eq("bad_ch_busy", 32'(busy_o), 32'd0);

    // Zero-period blink
    wr_cfg(2, 2, 0, 3, 0);
    run(12);
    check_eq("per0_led", 32'(led_o[2]), 32'd0);
    check_eq("per0_busy", 32'(busy_o[2]), 32'd1);

    // Reset in the middle of a burst
    wr_cfg(1, 3, 3, 2, 5);
    run(8);
    #1;
    do_reset(2);
    dones = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (done_o != '0) dones++;
    end
    check_eq("rst_no_done", 32'(dones), 32'd0);

    // Random config traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      cfg_if.cfg_we      = ($urandom_range(0, 5) == 0);
      cfg_if.cfg_ch      = 2'($urandom_range(0, 3));
      cfg_if.cfg_mode    = 2'($urandom_range(0, 3));
      cfg_if.cfg_period  = 16'($urandom_range(0, 5));
      cfg_if.cfg_on_time = 16'($urandom_range(0, 6));
      cfg_if.cfg_count   = 8'($urandom_range(0, 4));
      cycle();
    end
    cfg_if.cfg_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Multi-channel LED pattern generator for SoC GPIO-style LED outputs. It replaces the hard-wired single-LED blink with CH_NUM independently configured channels. Each channel is driven from one shared prescaled tick and supports OFF, ON, continuous BLINK with programmable duty, and BURST (N blinks, then a done pulse). It sits behind a simple write-only config port driven by the CPU wrapper or by top-level glue.

Parameters:
CH_NUM, 4, number of LED channels (1..32)
CNT_W, 16, width of period/on-time counters
BURST_W, 8, width of the burst repeat count
PRESCALE, 50000, clk cycles per tick (1 kHz tick at 50 MHz), >=1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run; low freezes prescaler, counters and outputs
cfg_we  in  1  one-cycle config write strobe
cfg_ch  in  max(1,$clog2(CH_NUM))  target channel
cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
cfg_period  in  CNT_W  ticks per blink cycle
cfg_on_time  in  CNT_W  ticks LED is high per cycle
cfg_count  in  BURST_W  blink cycles for BURST
led_o  out  CH_NUM  registered LED drive, bit i = channel i
busy_o  out  CH_NUM  channel in BLINK or BURST with cycles remaining
done_o  out  CH_NUM  one-cycle pulse when a BURST completes

Behaviour:
- Reset (async assert, sync release): prescaler=0; all channels OFF, counters 0; led_o, busy_o, done_o = 0.
- Prescaler: counts 0..PRESCALE-1 while enable=1. tick=1 in the cycle where count==PRESCALE-1, then wraps to 0. enable=0 holds the count. PRESCALE=1 gives tick every enabled cycle.
- Config write: cfg_we=1 with cfg_ch<CH_NUM latches mode/period/on_time/count into that channel. It also clears the channel's phase counter and done_o, and sets remaining=cfg_count. cfg_ch>=CH_NUM is ignored. A write takes priority over a same-cycle tick on that channel. The write acts regardless of enable.
- Output latency: led_o and busy_o reflect a write in the next cycle.
- Per-channel state machine, states S_OFF, S_ON, S_BLINK, S_BURST:
  - S_OFF: led=0, busy=0.
  - S_ON: led=1, busy=0.
  - S_BLINK: phase counts 0..period-1, advancing on tick. led = (phase < on_time). busy=1.
  - S_BURST: same as S_BLINK. On a tick with phase==period-1, remaining decrements. When it reaches 0, go to S_OFF, led=0, and pulse done_o for exactly one cycle.
- Boundary rules:
  - period==0 in BLINK: led=0, busy=1, no phase advance.
  - period==0 in BURST, or cfg_count==0: next cycle S_OFF with a done_o pulse and no LED activity.
  - on_time>=period: led stays high for the whole active time.
  - on_time==0: led stays low; the cycle count still advances.
  - Phase wrap: period-1 -> 0 on tick. No counter overflow, since phase < period <= 2^CNT_W-1.
- enable=0: all channel counters freeze and led_o holds its current value. done_o cannot fire. Config writes still apply; a newly written ON/OFF level shows immediately.
- Channels never interact except through the shared tick.
- reset_n asserted mid-burst: immediate return to the reset values; no done_o pulse.

Decomposition:
- Package led_blink_pkg holds:
  - mode constants MODE_OFF/ON/BLINK/BURST (2-bit);
  - the state encoding;
  - a per-channel config struct typedef (mode, period, on_time, count).
- Sub-module led_blink_chan: one channel FSM plus its phase and remaining counters. Inputs: tick, write strobe, config. Outputs: led, busy, done.
- led_blink_ctrl contains the prescaler, the cfg_ch decode and a generate loop of CH_NUM led_blink_chan instances.

Test Plan:
1. Reset/idle: hold reset_n=0, then release with no writes -> led_o=0, busy_o=0, done_o=0 for 100 cycles.
2. ON/OFF: write ch2 mode=ON -> led_o=4'b0100 one cycle after the write. Write ch2 OFF -> 0 next cycle.
3. BLINK duty (PRESCALE=4): ch0 period=4, on_time=1 -> led_o[0] high 4 clk, low 12 clk, repeating. Then on_time=5 -> constant high with busy_o[0]=1.
4. BURST: ch1 period=2, on_time=1, count=3 -> exactly 3 high pulses, then a single-cycle done_o[1], then busy_o[1]=0 and led_o[1]=0. count=0 -> done_o[1] next cycle with no pulses.
5. Mid-operation events:
   - a rewrite during a burst restarts phase at 0 with the new count, and the old burst never signals done;
   - a write coincident with a tick -> phase=0;
   - enable=0 mid-blink freezes led_o, and resumes the same phase after enable=1.
6. Corner config:
   - cfg_ch=CH_NUM (CH_NUM=3 build) -> no channel changes;
   - period=0 BLINK -> led=0, busy=1;
   - reset_n pulse mid-burst -> all outputs 0, no done_o.
